// File: rtl/obj_pkg.sv
// Object-layer shared definitions: object count, per-object sprite sizes, motion FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package obj_pkg;

   localparam int NUM_OBJ = 3;

   // Sprite footprint per object in pixels, index 0 is the rightmost entry.
   localparam logic [NUM_OBJ-1:0][11:0] ObjSizeX = {12'd24, 12'd32, 12'd16};
   localparam logic [NUM_OBJ-1:0][11:0] ObjSizeY = {12'd24, 12'd16, 12'd16};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      COMMIT = 2'd2
   } motion_state_t;

endpackage

// File: rtl/vga_hd_pkg.sv
// 720p raster geometry shared by the video pipeline.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_hd_pkg;

   localparam int ActivePels  = 1280;
   localparam int ActiveLines = 720;

endpackage

// File: rtl/obj_axis_step.sv
// One-axis position step with bounce against a low and a high border.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the parent presents an object.
module obj_axis_step #(
   parameter int VEL_W  = 8,
   parameter int ACTIVE = 1280
) (
   input  logic [11:0]      pos,
   input  logic [VEL_W-1:0] vel,
   input  logic [7:0]       lo_w,
   input  logic [7:0]       hi_w,
   input  logic [11:0]      size,
   output logic [11:0]      new_pos,
   output logic [VEL_W-1:0] new_vel,
   output logic             hit_lo,
   output logic             hit_hi
);

   localparam logic signed [13:0] ACT = 14'(ACTIVE);

   logic signed [13:0] vel_ext;
   logic signed [13:0] nx;
   logic signed [13:0] lo_lim;
   logic signed [13:0] hi_lim;
   logic               moving;

   assign vel_ext = 14'($signed(vel));
   assign nx      = $signed({2'b00, pos}) + vel_ext;
   assign lo_lim  = $signed({6'b0, lo_w});
   // Highest legal top-left coordinate so the sprite's far edge still touches the border.
   assign hi_lim  = ACT - $signed({6'b0, hi_w}) - $signed({2'b00, size});
   // A stationary object never bounces, even if the host parked it outside the borders.
   assign moving  = (vel != '0);

   // Clamp to the violated border and reflect the velocity; touching the border exactly is legal.
   always_comb begin
      new_pos = nx[11:0];
      new_vel = vel;
      hit_lo  = 1'b0;
      hit_hi  = 1'b0;
      if (moving && (nx < lo_lim)) begin
         new_pos = lo_lim[11:0];
         new_vel = -vel;
         hit_lo  = 1'b1;
      end else if (moving && (nx > hi_lim)) begin
         new_pos = hi_lim[11:0];
         new_vel = -vel;
         hit_hi  = 1'b1;
      end
   end

endmodule

// File: rtl/obj_motion_ctrl.sv
// Per-frame object motion: steps each enabled object once per frame_tick, commits all at once.
// Latency: tick at T -> busy T+1..T+1+NUM_OBJ, new positions from T+2+NUM_OBJ.
// Backpressure: wr_ready low while a sequence runs; ticks during a sequence are dropped and flagged.
module obj_motion_ctrl
   import obj_pkg::*;
   import vga_hd_pkg::*;
#(
   parameter int NUM_OBJ = obj_pkg::NUM_OBJ,
   parameter int VEL_W   = 8
) (
   input  logic                          vid_clk,
   input  logic                          vid_reset,
   input  logic                          frame_tick,
   input  logic [3:0][7:0]               frame_widths,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [$clog2(NUM_OBJ)-1:0]    wr_idx,
   input  logic [11:0]                   wr_x,
   input  logic [11:0]                   wr_y,
   input  logic [VEL_W-1:0]              wr_vx,
   input  logic [VEL_W-1:0]              wr_vy,
   input  logic                          wr_en,
   output logic [NUM_OBJ-1:0][11:0]      obj_x,
   output logic [NUM_OBJ-1:0][11:0]      obj_y,
   output logic [NUM_OBJ-1:0]            obj_en,
   output logic                          busy,
   output logic                          overrun,
   output logic [NUM_OBJ-1:0][3:0]       edge_hit
);

   localparam int               IDX_W      = $clog2(NUM_OBJ);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_OBJ - 1);
   localparam logic [VEL_W-1:0] VEL_MIN    = {1'b1, {(VEL_W-1){1'b0}}};
   localparam logic [VEL_W-1:0] VEL_MIN_P1 = {1'b1, {(VEL_W-2){1'b0}}, 1'b1};

   logic [1:0]                   rst_pipe;
   logic                         rst;
   motion_state_t                state, state_nxt;
   logic [IDX_W-1:0]             upd_idx;
   logic [NUM_OBJ-1:0][11:0]     work_x, work_y;
   logic [NUM_OBJ-1:0][VEL_W-1:0] work_vx, work_vy;
   logic [NUM_OBJ-1:0]           work_en;
   logic [NUM_OBJ-1:0][3:0]      hit_acc;
   logic                         wr_hit;
   logic [VEL_W-1:0]             wr_vx_sat, wr_vy_sat;
   logic [11:0]                  x_new, y_new;
   logic [VEL_W-1:0]             vx_new, vy_new;
   logic                         x_lo, x_hi, y_lo, y_hi;

   // Reset asserts immediately and releases two clocks after vid_reset drops.
   always_ff @(posedge vid_clk or posedge vid_reset) begin
      if (vid_reset) rst_pipe <= 2'b11;
      else           rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst = rst_pipe[1];

   assign wr_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign wr_hit    = wr_valid && wr_ready && (wr_idx <= LAST_IDX);
   // The most negative velocity has no positive counterpart, so it is pulled in by one.
   assign wr_vx_sat = (wr_vx == VEL_MIN) ? VEL_MIN_P1 : wr_vx;
   assign wr_vy_sat = (wr_vy == VEL_MIN) ? VEL_MIN_P1 : wr_vy;
   assign edge_hit  = (state == COMMIT) ? hit_acc : '0;

   // State register and object sweep counter.
   always_ff @(posedge vid_clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         upd_idx <= '0;
      end else begin
         state   <= state_nxt;
         upd_idx <= (state == UPDATE) ? upd_idx + 1'b1 : '0;
      end
   end

   // Next-state: one sweep per tick, one cycle per object, then a single commit cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_tick) state_nxt = UPDATE;
         UPDATE:  if (upd_idx == LAST_IDX) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   obj_axis_step #(.VEL_W(VEL_W), .ACTIVE(ActivePels)) u_step_x (
      .pos     (work_x[upd_idx]),
      .vel     (work_vx[upd_idx]),
      .lo_w    (frame_widths[0]),
      .hi_w    (frame_widths[1]),
      .size    (ObjSizeX[upd_idx]),
      .new_pos (x_new),
      .new_vel (vx_new),
      .hit_lo  (x_lo),
      .hit_hi  (x_hi)
   );

   obj_axis_step #(.VEL_W(VEL_W), .ACTIVE(ActiveLines)) u_step_y (
      .pos     (work_y[upd_idx]),
      .vel     (work_vy[upd_idx]),
      .lo_w    (frame_widths[2]),
      .hi_w    (frame_widths[3]),
      .size    (ObjSizeY[upd_idx]),
      .new_pos (y_new),
      .new_vel (vy_new),
      .hit_lo  (y_lo),
      .hit_hi  (y_hi)
   );

   // Host writes land in IDLE, sweep results in UPDATE, and the renderer copy refreshes in COMMIT.
   always_ff @(posedge vid_clk or posedge rst) begin
      if (rst) begin
         work_x  <= '0;
         work_y  <= '0;
         work_vx <= '0;
         work_vy <= '0;
         work_en <= '0;
         hit_acc <= '0;
         obj_x   <= '0;
         obj_y   <= '0;
         obj_en  <= '0;
      end else begin
         if (wr_hit) begin
            work_x[wr_idx]  <= wr_x;
            work_y[wr_idx]  <= wr_y;
            work_vx[wr_idx] <= wr_vx_sat;
            work_vy[wr_idx] <= wr_vy_sat;
            work_en[wr_idx] <= wr_en;
            obj_x[wr_idx]   <= wr_x;
            obj_y[wr_idx]   <= wr_y;
            obj_en[wr_idx]  <= wr_en;
         end
         if ((state == IDLE) && frame_tick) begin
            hit_acc <= '0;
         end
         if ((state == UPDATE) && work_en[upd_idx]) begin
            work_x[upd_idx]  <= x_new;
            work_y[upd_idx]  <= y_new;
            work_vx[upd_idx] <= vx_new;
            work_vy[upd_idx] <= vy_new;
            hit_acc[upd_idx] <= {y_hi, y_lo, x_hi, x_lo};
         end
         if (state == COMMIT) begin
            obj_x  <= work_x;
            obj_y  <= work_y;
            obj_en <= work_en;
         end
      end
   end

   // Sticky flag for ticks that arrive before the previous sweep has finished.
   always_ff @(posedge vid_clk or posedge rst) begin
      if (rst)                               overrun <= 1'b0;
      else if (frame_tick && (state != IDLE)) overrun <= 1'b1;
   end

endmodule

// File: doc/obj_motion_ctrl.md
OBJ_MOTION_CTRL -- requirements
Module: obj_motion_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_OBJ, obj_pkg::NUM_OBJ, number of objects managed.
- VEL_W, 8, signed velocity width in pixels/frame.
REQ-002 Ports SHALL be, one per line (clock and reset first):
- vid_clk  in  1  single clock.
- vid_reset  in  1  reset, asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse at start of vertical blanking.
- frame_widths  in  [3:0][7:0]  border widths: bottom, top, right, left ([0]=left).
- wr_valid  in  1  host write request.
- wr_ready  out  1  write accepted when high with wr_valid.
- wr_idx  in  $clog2(NUM_OBJ)  target object.
- wr_x / wr_y  in  12 each  new position.
- wr_vx / wr_vy  in  VEL_W each  new signed velocity.
- wr_en  in  1  new object enable.
- obj_x / obj_y  out  [NUM_OBJ-1:0][12]  committed positions to the renderer.
- obj_en  out  NUM_OBJ  committed enables.
- busy  out  1  update sequence in progress.
- overrun  out  1  sticky: frame_tick arrived while busy.
- edge_hit  out  [NUM_OBJ-1:0][3:0]  one-cycle bounce flags per object, same bit order as frame_widths.

Function
REQ-003 FSM states SHALL be IDLE, UPDATE, COMMIT.
REQ-004 IDLE -> UPDATE on frame_tick; UPDATE visits one object per cycle, index 0..NUM_OBJ-1; after the last index -> COMMIT; COMMIT -> IDLE after one cycle.
REQ-005 Latency: tick at cycle T -> busy high T+1..T+1+NUM_OBJ; new obj_x/obj_y/obj_en visible from T+2+NUM_OBJ, all objects changing in the same cycle.
REQ-006 Positions and velocities SHALL be held in working registers; obj_x/obj_y change only at COMMIT or on an accepted write.
REQ-007 wr_ready SHALL equal (state==IDLE); an accepted write updates the working and output registers of wr_idx on the next edge.
REQ-008 Write and frame_tick in the same IDLE cycle: both accepted; write applied first, so the update uses the written values.
REQ-009 wr_idx >= NUM_OBJ: write accepted and discarded.
REQ-010 Velocity value -2^(VEL_W-1) SHALL be stored as -(2^(VEL_W-1)-1).
REQ-011 Per enabled object: nx = x + vx, computed in 14-bit signed; same for y.
REQ-012 Left/top bounce: if nx < frame_widths[0], x = frame_widths[0], vx negated, edge_hit bit 0 set; top uses frame_widths[2] and bit 2.
REQ-013 Right/bottom bounce: if nx + ObjSizeX > ActivePels - frame_widths[1], x = ActivePels - frame_widths[1] - ObjSizeX, vx negated, bit 1 set; bottom uses ActiveLines, frame_widths[3], bit 3.
REQ-014 Exact contact (nx == limit) SHALL not bounce; vx = 0 SHALL never bounce.
REQ-015 Disabled objects keep position and velocity; their edge_hit stays 0.
REQ-016 edge_hit SHALL pulse for exactly the COMMIT cycle only.
REQ-017 frame_tick in UPDATE/COMMIT SHALL be ignored and set overrun; overrun clears only on reset.

Reset
REQ-018 On vid_reset (async assert, sync deassert internally): state IDLE; obj_x/obj_y, velocities, obj_en, busy, overrun, edge_hit all 0; a sequence in progress is abandoned without commit.

Structure
REQ-019 ObjSizeX/ObjSizeY and NUM_OBJ SHALL come from obj_pkg; ActivePels/ActiveLines from vga_hd_pkg; the state enum SHALL be added to obj_pkg.
REQ-020 Per-axis bounce arithmetic SHALL be one sub-module, obj_axis_step, instantiated for x and y.

Verification (ActivePels 1280, ActiveLines 720, ObjSizeX[0]=ObjSizeY[0]=16, frame_widths all 8)
REQ-021 Write obj0 x=100 y=100 vx=5 vy=-3 en=1, one tick -> after NUM_OBJ+2 cycles obj_x=105, obj_y=97, edge_hit[0]=0.
REQ-022 x=10 vx=-5, tick -> x=8, vx=+5, edge_hit[0]=4'b0001; next tick -> x=13.
REQ-023 x=1250 vx=10, tick -> x=1256, edge_hit[0]=4'b0010; x=1256 vx=0, tick -> no bounce.
REQ-024 Tick while busy -> overrun=1, no extra sequence; wr_valid while busy -> wr_ready=0, write applied only after return to IDLE.
REQ-025 Assert vid_reset mid-UPDATE -> all outputs 0 immediately, no commit; tick after release runs normally.
REQ-026 Write wr_vx=-128 -> stored -127; write wr_idx=NUM_OBJ -> no object changes.
